// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// Configurable UART receiver: 2-FF synchroniser, 3-sample majority vote around mid-bit,
// false-start rejection, parity / framing / break flags, one done tick per frame.
module uart_rx_cfg #(
    parameter int c_clkfreq    = 100_000_000,
    parameter int c_baudrate   = 115_200,
    parameter int c_databits   = 8,
    parameter int c_parity     = 0,
    parameter int c_stopbits   = 1,
    parameter int c_oversample = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in_i,
    output logic [c_databits-1:0] dout_o,
    output logic                  rx_done_tick_o,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  break_o,
    output logic                  busy_o,
    output logic [2:0]            state_dbg
);
    // rx_done_tick_o is a one-cycle valid with no ready: the consumer must take
    // dout_o and the flags on that cycle or later; they hold until the next tick.

    localparam int c_div  = c_clkfreq / (c_baudrate * c_oversample);
    localparam int c_divw = $clog2(c_div + 1);
    localparam int c_sw   = $clog2(c_oversample);
    localparam int c_bw   = $clog2(c_databits + 1 + c_stopbits + 1);

    typedef enum logic [2:0] {
        s_idle      = 3'd0,
        s_start     = 3'd1,
        s_data      = 3'd2,
        s_parity    = 3'd3,
        s_stop      = 3'd4,
        s_wait_high = 3'd5
    } state_t;

    state_t state, state_n;

    logic                  sync_q1, rxs;
    logic [c_divw-1:0]     div_cnt;
    logic [c_sw-1:0]       s_cnt;
    logic [c_bw-1:0]       bit_cnt;
    logic                  samp0, samp1;
    logic [c_databits-1:0] shreg;
    logic                  par_err, frame_acc, all_low;

    logic tick, smp_a, smp_b, dec, vote, last_data, last_stop, restart, finish, par_bad;

    assign tick      = (div_cnt == c_divw'(c_div - 1));
    assign smp_a     = tick && (s_cnt == c_sw'(c_oversample / 2 - 1));
    assign smp_b     = tick && (s_cnt == c_sw'(c_oversample / 2));
    assign dec       = tick && (s_cnt == c_sw'(c_oversample / 2 + 1));
    assign vote      = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
    assign last_data = (bit_cnt == c_bw'(c_databits - 1));
    assign last_stop = (bit_cnt == c_bw'(c_stopbits - 1));
    assign restart   = (state == s_idle) && !rxs;
    assign finish    = (state == s_stop) && dec && last_stop;
    // Odd mode flags an even total of ones, even mode an odd total.
    assign par_bad   = (c_parity == 1) ? ~(^shreg ^ vote) : (^shreg ^ vote);

    assign busy_o    = (state != s_idle);
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        case (state)
            s_idle:      if (!rxs) state_n = s_start;
            s_start:     if (dec) state_n = vote ? s_idle : s_data;
            s_data:      if (dec && last_data) state_n = (c_parity != 0) ? s_parity : s_stop;
            s_parity:    if (dec) state_n = s_stop;
            s_stop:      if (dec && last_stop) state_n = vote ? s_idle : s_wait_high;
            s_wait_high: if (rxs) state_n = s_idle;
            default:     state_n = s_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= s_idle;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1        <= 1'b1;
            rxs            <= 1'b1;
            div_cnt        <= '0;
            s_cnt          <= '0;
            bit_cnt        <= '0;
            samp0          <= 1'b0;
            samp1          <= 1'b0;
            shreg          <= '0;
            par_err        <= 1'b0;
            frame_acc      <= 1'b0;
            all_low        <= 1'b0;
            dout_o         <= '0;
            rx_done_tick_o <= 1'b0;
            parity_err_o   <= 1'b0;
            frame_err_o    <= 1'b0;
            break_o        <= 1'b0;
        end else begin
            sync_q1        <= rx_in_i;
            rxs            <= sync_q1;
            rx_done_tick_o <= finish;

            // Restarting both counters on the falling edge aligns the bit phase to it.
            if (restart || tick) div_cnt <= '0;
            else                 div_cnt <= div_cnt + c_divw'(1);

            if (restart)   s_cnt <= '0;
            else if (tick) s_cnt <= (s_cnt == c_sw'(c_oversample - 1)) ? '0 : s_cnt + c_sw'(1);

            if (smp_a) samp0 <= rxs;
            if (smp_b) samp1 <= rxs;

            if (dec) begin
                case (state)
                    s_start: begin
                        bit_cnt   <= '0;
                        par_err   <= 1'b0;
                        frame_acc <= 1'b0;
                        all_low   <= 1'b1;
                    end
                    s_data: begin
                        shreg   <= {vote, shreg[c_databits-1:1]};
                        all_low <= all_low & ~vote;
                        bit_cnt <= last_data ? '0 : bit_cnt + c_bw'(1);
                    end
                    s_parity: begin
                        par_err <= par_bad;
                        all_low <= all_low & ~vote;
                    end
                    s_stop: begin
                        frame_acc <= frame_acc | ~vote;
                        all_low   <= all_low & ~vote;
                        bit_cnt   <= bit_cnt + c_bw'(1);
                        if (last_stop) begin
                            dout_o       <= shreg;
                            parity_err_o <= par_err;
                            frame_err_o  <= frame_acc | ~vote;
                            break_o      <= all_low & ~vote;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// Bench for uart_rx_cfg: one default-rate 8N1 instance plus four 1 Mbaud instances
// (8N1, 8E1, 8N2, 9O2), table-driven frames and hand-written corner sequences.
module tb_uart_rx_cfg;
    localparam int n_dut       = 5;
    localparam int def_bit_ns  = 8681;
    localparam int fast_bit_ns = 960;   // 100 MHz / (1 Mbaud * 16) -> 6 clk per tick, 96 clk per bit
    localparam int fast_baud   = 1_000_000;
    localparam int n_vec       = 13;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       rx_line [n_dut];
    logic [7:0] dout8   [4];
    logic [8:0] dout9;
    logic       done    [n_dut];
    logic       pe      [n_dut];
    logic       fe      [n_dut];
    logic       brk     [n_dut];
    logic       busy    [n_dut];
    logic [2:0] st      [n_dut];

    uart_rx_cfg u_def (
        .clk(clk), .rst(rst), .rx_in_i(rx_line[0]), .dout_o(dout8[0]), .rx_done_tick_o(done[0]),
        .parity_err_o(pe[0]), .frame_err_o(fe[0]), .break_o(brk[0]), .busy_o(busy[0]), .state_dbg(st[0]));
    uart_rx_cfg #(.c_baudrate(fast_baud)) u_n1 (
        .clk(clk), .rst(rst), .rx_in_i(rx_line[1]), .dout_o(dout8[1]), .rx_done_tick_o(done[1]),
        .parity_err_o(pe[1]), .frame_err_o(fe[1]), .break_o(brk[1]), .busy_o(busy[1]), .state_dbg(st[1]));
    uart_rx_cfg #(.c_baudrate(fast_baud), .c_parity(2)) u_ev (
        .clk(clk), .rst(rst), .rx_in_i(rx_line[2]), .dout_o(dout8[2]), .rx_done_tick_o(done[2]),
        .parity_err_o(pe[2]), .frame_err_o(fe[2]), .break_o(brk[2]), .busy_o(busy[2]), .state_dbg(st[2]));
    uart_rx_cfg #(.c_baudrate(fast_baud), .c_stopbits(2)) u_s2 (
        .clk(clk), .rst(rst), .rx_in_i(rx_line[3]), .dout_o(dout8[3]), .rx_done_tick_o(done[3]),
        .parity_err_o(pe[3]), .frame_err_o(fe[3]), .break_o(brk[3]), .busy_o(busy[3]), .state_dbg(st[3]));
    uart_rx_cfg #(.c_baudrate(fast_baud), .c_databits(9), .c_parity(1), .c_stopbits(2)) u_9 (
        .clk(clk), .rst(rst), .rx_in_i(rx_line[4]), .dout_o(dout9), .rx_done_tick_o(done[4]),
        .parity_err_o(pe[4]), .frame_err_o(fe[4]), .break_o(brk[4]), .busy_o(busy[4]), .state_dbg(st[4]));

    // ---------------- helpers ----------------
    function automatic logic [14:0] pk(input int sel, input logic [8:0] d,
                                       input logic p, input logic f, input logic b);
        logic [2:0] s;
        s = sel[2:0];
        return {s, d, p, f, b};
    endfunction

    function logic [8:0] dout_of(input int i);
        logic [1:0] j;
        j = i[1:0];
        if (i == 4) return dout9;
        else        return {1'b0, dout8[j]};
    endfunction

    function automatic int bit_ns(input int sel);
        return (sel == 0) ? def_bit_ns : fast_bit_ns;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [14:0] got_q [$];
    logic [14:0] exp_q [$];
    int done_cnt [n_dut];
    int wh_cnt   [n_dut];
    int busy_cnt [n_dut];
    int rd_idx = 0;

    always @(negedge clk) begin
        for (int i = 0; i < n_dut; i++) begin
            if (done[i]) begin
                got_q.push_back(pk(i, dout_of(i), pe[i], fe[i], brk[i]));
                done_cnt[i]++;
            end
            if (st[i] == 3'd5) wh_cnt[i]++;
            if (busy[i])       busy_cnt[i]++;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic next_got(output logic [14:0] g);
        if (rd_idx < got_q.size()) begin
            g = got_q[rd_idx];
            rd_idx++;
        end else begin
            g = 15'h7fff;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input logic v);
        rx_line[sel] = v;
    endtask

    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        drive(sel, 1'b0);
        #(bit_ns(sel));
        for (int i = 0; i < n; i++) begin
            drive(sel, bits[i]);
            #(bit_ns(sel));
        end
    endtask

    task automatic idle(input int sel, input int nbits);
        drive(sel, 1'b1);
        #(nbits * bit_ns(sel));
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          sel;
        logic [15:0] bits;     // everything after the start bit, LSB first
        int          nbits;
        logic [14:0] exp;
        logic        exp_wh;
    } vec_t;

    vec_t vec [n_vec];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [14:0] g;
        int c0, w0, b0, sel;

        vec[0]  = '{0, 16'h01D2,  9, pk(0, 9'h0D2, 1'b0, 1'b0, 1'b0), 1'b0};
        vec[1]  = '{1, 16'h01A5,  9, pk(1, 9'h0A5, 1'b0, 1'b0, 1'b0), 1'b0};
        vec[2]  = '{1, 16'h005A,  9, pk(1, 9'h05A, 1'b0, 1'b1, 1'b0), 1'b1};
        vec[3]  = '{2, 16'h03D2, 10, pk(2, 9'h0D2, 1'b1, 1'b0, 1'b0), 1'b0};
        vec[4]  = '{2, 16'h02D2, 10, pk(2, 9'h0D2, 1'b0, 1'b0, 1'b0), 1'b0};
        vec[5]  = '{2, 16'h0307, 10, pk(2, 9'h007, 1'b0, 1'b0, 1'b0), 1'b0};
        vec[6]  = '{2, 16'h0000, 10, pk(2, 9'h000, 1'b0, 1'b1, 1'b1), 1'b1};
        vec[7]  = '{3, 16'h013C, 10, pk(3, 9'h03C, 1'b0, 1'b1, 1'b0), 1'b1};
        vec[8]  = '{3, 16'h03C3, 10, pk(3, 9'h0C3, 1'b0, 1'b0, 1'b0), 1'b0};
        vec[9]  = '{3, 16'h0281, 10, pk(3, 9'h081, 1'b0, 1'b1, 1'b0), 1'b0};
        vec[10] = '{4, 16'h0DA5, 12, pk(4, 9'h1A5, 1'b0, 1'b0, 1'b0), 1'b0};
        vec[11] = '{4, 16'h0CF0, 12, pk(4, 9'h0F0, 1'b1, 1'b0, 1'b0), 1'b0};
        vec[12] = '{4, 16'h0D00, 12, pk(4, 9'h100, 1'b0, 1'b0, 1'b0), 1'b0};

        rst = 1'b1;
        for (int i = 0; i < n_dut; i++) rx_line[i] = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < n_dut; i++)
            check($sformatf("reset_dut%0d", i),
                  {15'd0, dout_of(i), pe[i], fe[i], brk[i], done[i], busy[i], st[i]}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // table-driven frames
        for (int k = 0; k < n_vec; k++) begin
            sel = vec[k].sel;
            @(negedge clk);
            c0 = done_cnt[sel];
            w0 = wh_cnt[sel];
            exp_q.push_back(vec[k].exp);
            send_bits(sel, vec[k].bits, vec[k].nbits);
            idle(sel, 2);
            check($sformatf("v%0d_done_busy", k), (done_cnt[sel] - c0) * 2 + int'(busy[sel]), 32'd2);
            next_got(g);
            check($sformatf("v%0d_data", k), {17'd0, g}, {17'd0, exp_q.pop_front()});
            check($sformatf("v%0d_wait_high", k), {31'd0, wh_cnt[sel] != w0}, {31'd0, vec[k].exp_wh});
        end

        // false start: low well under half a bit, then a good frame
        @(negedge clk);
        c0 = done_cnt[1];
        b0 = busy_cnt[1];
        drive(1, 1'b0);
        #300;
        idle(1, 2);
        check("fs_no_done", done_cnt[1] - c0, 32'd0);
        check("fs_busy_seen", {31'd0, busy_cnt[1] != b0}, 32'd1);
        check("fs_busy_low", {31'd0, busy[1]}, 32'd0);
        send_bits(1, 16'h01A5, 9);
        idle(1, 2);
        check("fs_then_done", done_cnt[1] - c0, 32'd1);
        next_got(g);
        check("fs_then_data", {17'd0, g}, {17'd0, pk(1, 9'h0A5, 1'b0, 1'b0, 1'b0)});

        // break: 12 bit periods low gives exactly one frame, then a normal frame
        @(negedge clk);
        c0 = done_cnt[1];
        drive(1, 1'b0);
        #(12 * fast_bit_ns);
        check("brk_one_done", done_cnt[1] - c0, 32'd1);
        next_got(g);
        check("brk_data", {17'd0, g}, {17'd0, pk(1, 9'h000, 1'b0, 1'b1, 1'b1)});
        check("brk_in_wait_high", {29'd0, st[1]}, 32'd5);
        idle(1, 1);
        send_bits(1, 16'h0155, 9);
        idle(1, 2);
        check("brk_then_done", done_cnt[1] - c0, 32'd2);
        next_got(g);
        check("brk_then_data", {17'd0, g}, {17'd0, pk(1, 9'h055, 1'b0, 1'b0, 1'b0)});

        // reset during data bit 3 aborts the frame
        @(negedge clk);
        c0 = done_cnt[1];
        drive(1, 1'b0);
        #(4 * fast_bit_ns + fast_bit_ns / 2);
        check("rst_pre_busy", {31'd0, busy[1]}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_outputs", {17'd0, dout_of(1), pe[1], fe[1], brk[1], done[1], busy[1]}, 32'd0);
        drive(1, 1'b1);
        #50;
        @(negedge clk);
        rst = 1'b0;
        idle(1, 2);
        check("rst_no_done", done_cnt[1] - c0, 32'd0);

        // back-to-back frames with no idle gap
        send_bits(1, 16'h0181, 9);
        send_bits(1, 16'h017E, 9);
        idle(1, 2);
        check("b2b_done", done_cnt[1] - c0, 32'd2);
        next_got(g);
        check("b2b_data1", {17'd0, g}, {17'd0, pk(1, 9'h081, 1'b0, 1'b0, 1'b0)});
        next_got(g);
        check("b2b_data2", {17'd0, g}, {17'd0, pk(1, 9'h07E, 1'b0, 1'b0, 1'b0)});

        check("no_stray_done", got_q.size() - rd_idx, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
